mul_gen: RTL and testbench

Parametrised sequential shift-add multiplier, successor to the fixed 8-bit `mul`. It multiplies two WIDTH-bit operands in unsigned or two's-complement mode. It uses the same start/busy handshake and keeps the external shared-adder interface, so the team `sum` instance stays outside the block. It adds a one-cycle done pulse, signed operation with a final negate pass through the shared adder, and an optional early exit.

---
 rtl/mul_gen_pkg.sv | 16 +
 rtl/mul_gen.sv | 122 ++++++++++++
 tb/tb_mul_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mul_gen_pkg.sv
// Shared types for the mul_gen sequential multiplier: FSM state encoding and
// the helper that sizes the iteration counter.
package mul_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2
    } state_t;

    // Counter wide enough to hold WIDTH-1 with headroom for the increment.
    function automatic int mul_gen_width_t(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_gen.sv
// Parametrised shift-add multiplier (unsigned or two's complement) driving an
// external shared adder. Define MUL_GEN_EARLY_EXIT_EN to stop RUN once the multiplier is exhausted.
//
// Handshake: start is accepted only in IDLE; busy rises on the accepting edge and
// falls on the edge where done pulses for one cycle and result becomes valid.
module mul_gen
    import mul_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [2*WIDTH-1:0] sum_in_a,
    output logic [2*WIDTH-1:0] sum_in_b,
    input  logic [2*WIDTH-1:0] sum_out,
    output state_t             dbg_state
);

    localparam int               W2       = 2 * WIDTH;
    localparam int               CNT_W    = mul_gen_width_t(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [W2-1:0]    ONE_W2   = W2'(1);

    state_t           state, state_nxt;
    logic [W2-1:0]    mcand, mplr, acc;
    logic [W2-1:0]    mplr_shr;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag, b_mag;

    // The most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
    assign a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + ONE_W) : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + ONE_W) : b_i;

    assign mplr_shr  = mplr >> 1;
    assign dbg_state = state;

`ifdef MUL_GEN_EARLY_EXIT_EN
    assign last_iter = (cnt == CNT_LAST) || (mplr_shr == '0);
`else
    assign last_iter = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sum_in_a  = '0;
        sum_in_b  = '0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                sum_in_a = acc;
                sum_in_b = mplr[0] ? mcand : '0;
                if (last_iter) state_nxt = neg ? NEG : IDLE;
            end
            NEG: begin
                // Two's-complement negate; a zero product stays zero.
                sum_in_a  = ~acc;
                sum_in_b  = ONE_W2;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mcand <= {{WIDTH{1'b0}}, a_mag};
                    mplr  <= {{WIDTH{1'b0}}, b_mag};
                    neg   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                RUN: begin
                    acc   <= sum_out;
                    mcand <= mcand << 1;
                    mplr  <= mplr_shr;
                    cnt   <= cnt + CNT_ONE;
                    if (last_iter && !neg) begin
                        result <= sum_out;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                NEG: begin
                    result <= sum_out;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_gen.sv
// Directed bench for mul_gen (WIDTH=8) with an external adder model, a result
// scoreboard and busy-latency checks; follows MUL_GEN_EARLY_EXIT_EN if defined.
module tb_mul_gen;
  import mul_gen_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           signed_i;
  logic           start;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [2*W-1:0] sum_in_a;
  logic [2*W-1:0] sum_in_b;
  logic [2*W-1:0] sum_out;
  state_t         dbg_state;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             n_cmp = 0;
  int             n_err = 0;

  mul_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .signed_i(signed_i),
    .start(start), .busy(busy), .done(done), .result(result),
    .sum_in_a(sum_in_a), .sum_in_b(sum_in_b), .sum_out(sum_out),
    .dbg_state(dbg_state)
  );

  // Stand-in for the shared sum instance.
  assign sum_out = sum_in_a + sum_in_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
    logic [2*W-1:0] ax, bx;
    ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ax * bx;
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic n;
    int   r;
    n = s & (a[W-1] ^ b[W-1]);
`ifdef MUL_GEN_EARLY_EXIT_EN
    begin
      logic [W-1:0] bm;
      bm = (s && b[W-1]) ? (~b + 8'd1) : b;
      r = 1;
      for (int i = 0; i < W; i++) if (bm[i]) r = i + 1;
    end
`else
    r = W;
`endif
    return r + int'(n);
  endfunction

  // Drive one operation from a negedge and score it when done arrives.
  // hold keeps start high while busy; settle checks the idle cycle after done.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit hold, input bit settle);
    int lat;
    bit seen;
    exp_q.push_back(model_prod(a, b, s));
    lat_q.push_back(model_lat(a, b, s));
    a_i = a; b_i = b; signed_i = s; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom); signed_i = 1'($urandom_range(0, 1));
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) lat++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_q.pop_front()));
    check({tag, "_busy_cycles"}, 32'(lat), 32'(lat_q.pop_front()));
    if (settle) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_sum_in", {sum_in_a, sum_in_b}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    run_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b0, 1'b1);
    run_op("s_m3x5", 8'hFD, 8'd5, 1'b1, 1'b0, 1'b1);
    run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    run_op("s_m7x0", 8'hF9, 8'd0, 1'b1, 1'b0, 1'b1);
    run_op("u7x0", 8'd7, 8'd0, 1'b0, 1'b0, 1'b1);
    run_op("u200x3", 8'd200, 8'd3, 1'b0, 1'b0, 1'b1);
    run_op("u1x128", 8'd1, 8'd128, 1'b0, 1'b0, 1'b1);

    // Abort 100*100 during its 4th RUN cycle.
    a_i = 8'd100; b_i = 8'd100; signed_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_sum_in", {sum_in_a, sum_in_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst_3x2", 8'd3, 8'd2, 1'b0, 1'b0, 1'b1);

    run_op("hold_5x5", 8'd5, 8'd5, 1'b0, 1'b1, 1'b0);
    run_op("b2b_4x3", 8'd4, 8'd3, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++)
      run_op("random", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
